// File: rtl/state_machine_if.sv
// Score inputs and load/light outputs between the Baccarat control FSM and its datapath.
// master is the FSM side; slave is the card/score datapath side.
interface state_machine_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light
  );
endinterface

// File: rtl/state_machine.sv
// Baccarat deal/decision FSM: one load pulse per cycle, DONE 5-7 cycles after leaving IDLE.
// No backpressure: advances every slow_clock edge; DONE holds until reset.
module state_machine (
  input  logic           slow_clock,
  input  logic           resetb,
  state_machine_if.master bus
);

  typedef enum logic [2:0] {IDLE, PC1, DC1, PC2, DC2, PC3, DC3, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] pcard3_val;
  logic       banker_draws;

  always_ff @(posedge slow_clock) begin
    if (resetb) state <= IDLE;
    else        state <= state_nxt;
  end

  // Face cards, tens and "no card" all count zero in the banker table.
  always_comb begin
    pcard3_val = bus.pcard3;
    if (bus.pcard3 >= 4'd10 || bus.pcard3 == 4'd0) pcard3_val = 4'd0;
  end

  always_comb begin
    banker_draws = 1'b0;
    case (bus.dscore)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (pcard3_val != 4'd8);
      4'd4:             banker_draws = (pcard3_val >= 4'd2) && (pcard3_val <= 4'd7);
      4'd5:             banker_draws = (pcard3_val >= 4'd4) && (pcard3_val <= 4'd7);
      4'd6:             banker_draws = (pcard3_val >= 4'd6) && (pcard3_val <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = PC1;
      PC1:  state_nxt = DC1;
      DC1:  state_nxt = PC2;
      PC2:  state_nxt = DC2;
      DC2: begin
        if (bus.pscore >= 4'd8 || bus.dscore >= 4'd8) state_nxt = DONE;
        else if (bus.pscore <= 4'd5)                  state_nxt = PC3;
        else if (bus.dscore <= 4'd5)                  state_nxt = DC3;
        else                                          state_nxt = DONE;
      end
      PC3:     state_nxt = banker_draws ? DC3 : DONE;
      DC3:     state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  // Outputs are forced low while reset is asserted, even before the first edge.
  always_comb begin
    bus.load_pcard1      = 1'b0;
    bus.load_pcard2      = 1'b0;
    bus.load_pcard3      = 1'b0;
    bus.load_dcard1      = 1'b0;
    bus.load_dcard2      = 1'b0;
    bus.load_dcard3      = 1'b0;
    bus.player_win_light = 1'b0;
    bus.dealer_win_light = 1'b0;
    if (!resetb) begin
      case (state)
        PC1: bus.load_pcard1 = 1'b1;
        DC1: bus.load_dcard1 = 1'b1;
        PC2: bus.load_pcard2 = 1'b1;
        DC2: bus.load_dcard2 = 1'b1;
        PC3: bus.load_pcard3 = 1'b1;
        DC3: bus.load_dcard3 = 1'b1;
        DONE: begin
          bus.player_win_light = (bus.pscore >= bus.dscore);
          bus.dealer_win_light = (bus.dscore >= bus.pscore);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_state_machine.sv
// Self-checking bench for state_machine: directed and random hands against a Baccarat rules model.
module tb_state_machine;

  localparam int HAND_LEN = 11;
  localparam int N_RAND   = 40;

  logic slow_clock = 1'b0;
  logic resetb     = 1'b1;

  state_machine_if sm_if ();

  state_machine dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (sm_if.master)
  );

  always #5 slow_clock = ~slow_clock;

  logic [7:0] outs;
  assign outs = {sm_if.load_pcard1, sm_if.load_pcard2, sm_if.load_pcard3,
                 sm_if.load_dcard1, sm_if.load_dcard2, sm_if.load_dcard3,
                 sm_if.player_win_light, sm_if.dealer_win_light};

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] obs_q [$];
  logic [7:0] exp_q [$];
  logic [9:0] draw_mask [0:15];

  function automatic logic [1:0] lights(input logic [3:0] p, input logic [3:0] d);
    if (p > d)      return 2'b10;
    else if (d > p) return 2'b01;
    else            return 2'b11;
  endfunction

  // Expected observation list: IDLE, four deal pulses, optional third cards, then DONE repeated.
  task automatic build_expect(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3,
                              input logic [3:0] pe, input logic [3:0] de);
    logic       natural, pdraw, bdraw;
    int         v;
    logic [9:0] m;
    exp_q = {8'h00, 8'h80, 8'h10, 8'h40, 8'h08};
    natural = (ps >= 8) || (ds >= 8);
    pdraw   = !natural && (ps <= 5);
    if (natural)     bdraw = 1'b0;
    else if (!pdraw) bdraw = (ds <= 5);
    else begin
      v     = (pc3 >= 10 || pc3 == 0) ? 0 : int'(pc3);
      m     = draw_mask[ds];
      bdraw = m[v];
    end
    if (pdraw) exp_q.push_back(8'h20);
    if (bdraw) exp_q.push_back(8'h04);
    while (exp_q.size() < HAND_LEN) exp_q.push_back({6'b0, lights(pe, de)});
  endtask

  // Deal scores stay until the PC3 decision is past; then final scores are presented.
  task automatic play_hand(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3,
                           input logic [3:0] pe, input logic [3:0] de);
    resetb        = 1'b1;
    sm_if.pscore  = ps;
    sm_if.dscore  = ds;
    sm_if.pcard3  = pc3;
    repeat (2) @(negedge slow_clock);
    resetb = 1'b0;
    #1;
    obs_q = {};
    obs_q.push_back(outs);
    for (int k = 1; k < HAND_LEN; k++) begin
      @(negedge slow_clock);
      if (k >= 5 && !sm_if.load_pcard3) begin
        sm_if.pscore = pe;
        sm_if.dscore = de;
      end
      #1;
      obs_q.push_back(outs);
    end
  endtask

  task automatic test_reset();
    resetb       = 1'b1;
    sm_if.pscore = 4'd5;
    sm_if.dscore = 4'd5;
    sm_if.pcard3 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge slow_clock);
      n_cmp++;
      if (outs !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, outs, 8'h00);
      end
    end
  endtask

  task automatic test_directed();
    logic [19:0] tab [8];
    logic [19:0] t;
    tab = '{20'h16711, 20'h72091, 20'h89089, 20'h77077,
            20'h00509, 20'h23843, 20'h23C43, 20'h66066};
    for (int c = 0; c < 8; c++) begin
      t = tab[c];
      build_expect(t[19:16], t[15:12], t[11:8], t[7:4], t[3:0]);
      play_hand(t[19:16], t[15:12], t[11:8], t[7:4], t[3:0]);
      for (int i = 0; i < HAND_LEN; i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL directed%0d[%0d] (%h): got %b want %b", c, i, t, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hand();
    play_hand(4'd4, 4'd4, 4'd3, 4'd4, 4'd4);
    resetb = 1'b1;
    @(negedge slow_clock);
    n_cmp++;
    if (outs !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_in_done: got %b want %b", outs, 8'h00);
    end
    resetb = 1'b0;
    @(negedge slow_clock);
    @(negedge slow_clock);
    n_cmp++;
    if (outs !== 8'h10) begin
      n_bad++;
      $display("FAIL reach_dc1: got %b want %b", outs, 8'h10);
    end
    resetb = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_held_dc1: got %b want %b", outs, 8'h00);
    end
    @(negedge slow_clock);
    n_cmp++;
    if (outs !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_to_idle: got %b want %b", outs, 8'h00);
    end
    resetb = 1'b0;
    @(negedge slow_clock);
    n_cmp++;
    if (outs !== 8'h80) begin
      n_bad++;
      $display("FAIL restart_pc1: got %b want %b", outs, 8'h80);
    end
  endtask

  task automatic test_random();
    logic [3:0] ps, ds, pc3, pe, de;
    for (int h = 0; h < N_RAND; h++) begin
      ps  = 4'($urandom_range(0, 9));
      ds  = 4'($urandom_range(0, 9));
      pc3 = 4'($urandom_range(0, 13));
      pe  = 4'($urandom_range(0, 9));
      de  = 4'($urandom_range(0, 9));
      build_expect(ps, ds, pc3, pe, de);
      play_hand(ps, ds, pc3, pe, de);
      for (int i = 0; i < HAND_LEN; i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL random%0d[%0d] p=%0d d=%0d c3=%0d pe=%0d de=%0d: got %b want %b",
                   h, i, ps, ds, pc3, pe, de, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    // Banker draw table after a player third card, indexed by dealer score, bit = card value.
    for (int i = 0; i < 16; i++) draw_mask[i] = 10'h000;
    draw_mask[0] = 10'h3FF;
    draw_mask[1] = 10'h3FF;
    draw_mask[2] = 10'h3FF;
    draw_mask[3] = 10'h2FF;
    draw_mask[4] = 10'h0FC;
    draw_mask[5] = 10'h0F0;
    draw_mask[6] = 10'h0C0;
    sm_if.pscore = 4'd0;
    sm_if.dscore = 4'd0;
    sm_if.pcard3 = 4'd0;

    test_reset();
    test_directed();
    test_reset_mid_hand();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
